// File: rtl/bpm_filter_pkg.sv
// Shared definitions for the BPM-driven threshold filter: filter modes and
// the BPM-to-threshold mapping.
package bpm_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_BINARY = 2'd2,
        MODE_SUB    = 2'd3
    } mode_t;

    // Full-width product before the shift so large BPM values saturate instead of wrapping.
    function automatic logic [31:0] bpm_target(input logic [31:0] bpm, input int step,
                                               input int frac, input int bits);
        logic [63:0] prod_s;
        logic [63:0] max_s;
        prod_s = (64'(bpm) * 64'(unsigned'(step))) >> frac;
        max_s  = (64'd1 << bits) - 64'd1;
        if (prod_s > max_s) begin
            return max_s[31:0];
        end else begin
            return prod_s[31:0];
        end
    endfunction

endpackage

// File: rtl/thr_channel_op.sv
// Combinational threshold operation on one colour channel; also flags
// whether the channel lies strictly above the threshold.
module thr_channel_op
    import bpm_filter_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] pix,
    input  logic [BITS-1:0] thr,
    input  mode_t           mode,
    input  logic            enable,
    output logic [BITS-1:0] res,
    output logic            above
);

    // Mode selection; "above" is independent of mode so counting never depends on it.
    always_comb begin
        above = (pix > thr);
        res   = pix;
        if (!enable) begin
            res = pix;
        end else begin
            case (mode)
                MODE_BYPASS: res = pix;
                MODE_ZERO:   res = above ? pix : {BITS{1'b0}};
                MODE_BINARY: res = above ? {BITS{1'b1}} : {BITS{1'b0}};
                MODE_SUB:    res = above ? (pix - thr) : {BITS{1'b0}};
                default:     res = pix;
            endcase
        end
    end

endmodule

// File: rtl/bpm_threshold_pipe.sv
// Registered pixel threshold filter whose threshold ramps once per frame
// toward a BPM-derived target, with a per-frame above-threshold pixel count.
module bpm_threshold_pipe
    import bpm_filter_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int BITS      = 8,
    parameter int MAX_BPM   = 200,
    parameter int FRAC      = 8,
    parameter int STEP_SIZE = ((1 << BITS) * (1 << FRAC)) / MAX_BPM,
    parameter int RAMP_STEP = 16,
    parameter int CNT_W     = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*BITS-1:0]     pix_in,
    input  logic                         valid_in,
    input  logic                         sof_in,
    output logic                         module_ready,
    input  logic                         filter_enable,
    input  logic [1:0]                   mode,
    input  logic [$clog2(MAX_BPM+1)-1:0] BPM_estimate,
    output logic [CHANNELS*BITS-1:0]     pix_out,
    output logic                         valid_out,
    output logic                         sof_out,
    input  logic                         output_ready,
    output logic [BITS-1:0]              thr_current,
    output logic [CNT_W-1:0]             frame_above_count,
    output logic                         frame_above_valid
);

    localparam int MAXV = (1 << BITS) - 1;
    // A ramp step at or beyond full scale behaves like an immediate jump.
    localparam logic [BITS-1:0] RAMP_V = (RAMP_STEP > MAXV) ? BITS'(MAXV) : BITS'(RAMP_STEP);

    logic                     accept_s;
    logic [BITS-1:0]          tgt_s;
    logic [BITS-1:0]          diff_s;
    logic [BITS-1:0]          thr_next_s;
    logic [BITS-1:0]          thr_use_s;
    logic [CHANNELS*BITS-1:0] res_s;
    logic [CHANNELS-1:0]      above_s;
    logic                     above_any_s;
    logic [CNT_W-1:0]         run_cnt_r;
    logic                     seen_sof_r;

    assign module_ready = !valid_out || output_ready;
    assign accept_s     = valid_in && module_ready;
    assign tgt_s        = BITS'(bpm_target(32'(BPM_estimate), STEP_SIZE, FRAC, BITS));
    assign thr_use_s    = sof_in ? thr_next_s : thr_current;
    assign above_any_s  = |above_s;

    // Next threshold: move at most RAMP_V toward the target (or jump when ramping is off).
    always_comb begin
        diff_s     = {BITS{1'b0}};
        thr_next_s = tgt_s;
        if (RAMP_STEP == 0) begin
            thr_next_s = tgt_s;
        end else if (tgt_s >= thr_current) begin
            diff_s     = tgt_s - thr_current;
            thr_next_s = (diff_s <= RAMP_V) ? tgt_s : (thr_current + RAMP_V);
        end else begin
            diff_s     = thr_current - tgt_s;
            thr_next_s = (diff_s <= RAMP_V) ? tgt_s : (thr_current - RAMP_V);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        thr_channel_op #(.BITS(BITS)) u_op (
            .pix    (pix_in[c*BITS +: BITS]),
            .thr    (thr_use_s),
            .mode   (mode_t'(mode)),
            .enable (filter_enable),
            .res    (res_s[c*BITS +: BITS]),
            .above  (above_s[c])
        );
    end

    // Output register, threshold state and per-frame counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_out           <= {(CHANNELS*BITS){1'b0}};
            valid_out         <= 1'b0;
            sof_out           <= 1'b0;
            thr_current       <= {BITS{1'b0}};
            frame_above_count <= {CNT_W{1'b0}};
            frame_above_valid <= 1'b0;
            run_cnt_r         <= {CNT_W{1'b0}};
            seen_sof_r        <= 1'b0;
        end else begin
            frame_above_valid <= 1'b0;
            if (accept_s) begin
                pix_out   <= res_s;
                sof_out   <= sof_in;
                valid_out <= 1'b1;
                if (sof_in) begin
                    thr_current <= thr_next_s;
                    seen_sof_r  <= 1'b1;
                    run_cnt_r   <= above_any_s ? CNT_W'(1'b1) : {CNT_W{1'b0}};
                    // Pixels seen before the first sof do not form a complete frame.
                    if (seen_sof_r) begin
                        frame_above_count <= run_cnt_r;
                        frame_above_valid <= 1'b1;
                    end else begin
                        frame_above_valid <= 1'b0;
                    end
                end else if (above_any_s && (run_cnt_r != {CNT_W{1'b1}})) begin
                    run_cnt_r <= run_cnt_r + CNT_W'(1'b1);
                end else begin
                    run_cnt_r <= run_cnt_r;
                end
            end else if (output_ready) begin
                valid_out <= 1'b0;
            end else begin
                valid_out <= valid_out;
            end
        end
    end

endmodule
